// File: rtl/game_pkg.sv
// Shared types and helpers for the game state controller and its scan datapath.
// Pure declarations: no timing, no flow control.
package game_pkg;

  typedef enum logic [1:0] {PLAY, POWER, DYING, OVER} game_state_t;
  typedef enum logic [1:0] {IDLE, SCAN, COMMIT} scan_state_t;

  localparam int FRUIT_PTS_DEF = 50;
  localparam int GHOST_PTS_DEF = 200;

  // Up to 8 entities of each kind, so an 8-bit count input covers every build.
  function automatic logic [3:0] popcount8(input logic [7:0] v);
    logic [3:0] c;
    c = '0;
    for (int i = 0; i < 8; i++) c = c + {3'b000, v[i]};
    return c;
  endfunction

endpackage

// File: rtl/point_dist_sq.sv
// Combinational squared Euclidean distance between two pixel points; zero latency.
// No flow control: the output follows the inputs within the same cycle.
module point_dist_sq #(
  parameter int COORD_W = 10
) (
  input  logic [COORD_W-1:0]   ax,
  input  logic [COORD_W-1:0]   ay,
  input  logic [COORD_W-1:0]   bx,
  input  logic [COORD_W-1:0]   by,
  output logic [2*COORD_W+2:0] dist_sq
);

  localparam int DW = 2*COORD_W + 3;

  logic signed [COORD_W:0] dx, dy;
  logic [DW-1:0] dx_e, dy_e;

  assign dx = $signed({1'b0, ax}) - $signed({1'b0, bx});
  assign dy = $signed({1'b0, ay}) - $signed({1'b0, by});

  // Two's-complement squares are exact modulo 2^DW, and the true square fits.
  assign dx_e = {{(COORD_W+2){dx[COORD_W]}}, dx};
  assign dy_e = {{(COORD_W+2){dy[COORD_W]}}, dy};
  assign dist_sq = dx_e * dx_e + dy_e * dy_e;

endmodule

// File: rtl/game_state_ctrl.sv
// Lives / power / death / score tracking with a once-per-frame collision scan.
// Commit lands NUM_GHOSTS+NUM_FRUITS+1 Clks after frame_tick; ticks during a scan are dropped and flagged.
module game_state_ctrl
  import game_pkg::*;
#(
  parameter int NUM_GHOSTS    = 3,
  parameter int NUM_FRUITS    = 3,
  parameter int COORD_W       = 10,
  parameter int LIVES_INIT    = 2,
  parameter int LIVES_W       = 2,
  parameter int POWER_FRAMES  = 600,
  parameter int DEATH_FRAMES  = 120,
  parameter int HIT_RADIUS_SQ = 64,
  parameter int SCORE_W       = 16,
  parameter int FRUIT_PTS     = FRUIT_PTS_DEF,
  parameter int GHOST_PTS     = GHOST_PTS_DEF
) (
  input  logic                          Clk,
  input  logic                          Reset,
  input  logic                          frame_tick,
  input  logic [COORD_W-1:0]            pacman_x,
  input  logic [COORD_W-1:0]            pacman_y,
  input  logic [NUM_GHOSTS*COORD_W-1:0] ghost_x,
  input  logic [NUM_GHOSTS*COORD_W-1:0] ghost_y,
  input  logic [NUM_FRUITS*COORD_W-1:0] fruit_x,
  input  logic [NUM_FRUITS*COORD_W-1:0] fruit_y,
  output logic [NUM_GHOSTS-1:0]         ghost_enable,
  output logic [NUM_FRUITS-1:0]         fruit_on,
  output logic                          reversal,
  output logic                          isDefeated,
  output logic                          respawn,
  output logic                          death,
  output logic [LIVES_W-1:0]            lives,
  output logic [SCORE_W-1:0]            score,
  output logic                          scan_overrun
);

  localparam int NUM_ENT = NUM_GHOSTS + NUM_FRUITS;
  localparam int IDX_W   = 5;
  localparam int DIST_W  = 2*COORD_W + 3;
  localparam int PWR_W   = $clog2(POWER_FRAMES + 1);
  localparam int DTH_W   = $clog2(DEATH_FRAMES + 1);
  localparam logic [32:0] SCORE_MAX = (33'd1 << SCORE_W) - 33'd1;

  scan_state_t               scan_q, scan_d;
  logic [IDX_W-1:0]          idx_q;
  logic [COORD_W-1:0]        pac_x_q, pac_y_q, ent_x, ent_y;
  logic                      ent_on, hit, overrun_q;
  logic [NUM_GHOSTS-1:0]     ghost_hit_q;
  logic [NUM_FRUITS-1:0]     fruit_hit_q;
  logic [DIST_W-1:0]         dist_sq;

  game_state_t               game_q, game_d;
  logic [LIVES_W-1:0]        lives_q, lives_d;
  logic [PWR_W-1:0]          power_q, power_d;
  logic [DTH_W-1:0]          death_q, death_d;
  logic [SCORE_W-1:0]        score_q, score_d;
  logic [NUM_GHOSTS-1:0]     gen_q, gen_d;
  logic [NUM_FRUITS-1:0]     fon_q, fon_d;
  logic                      defeated_q, defeated_d, respawn_q, respawn_d;
  logic [31:0]               fruit_add, ghost_add;

  function automatic logic [SCORE_W-1:0] sat_add(input logic [SCORE_W-1:0] s,
                                                 input logic [31:0] a);
    logic [32:0] sum;
    sum = 33'(s) + {1'b0, a};
    return (sum > SCORE_MAX) ? SCORE_W'(SCORE_MAX) : SCORE_W'(sum);
  endfunction

  // Entity mux: ghosts first, then fruits; ghost positions are taken live.
  always_comb begin
    ent_x  = '0;
    ent_y  = '0;
    ent_on = 1'b0;
    for (int i = 0; i < NUM_GHOSTS; i++) begin
      if (idx_q == IDX_W'(i)) begin
        ent_x  = ghost_x[i*COORD_W +: COORD_W];
        ent_y  = ghost_y[i*COORD_W +: COORD_W];
        ent_on = gen_q[i];
      end
    end
    for (int j = 0; j < NUM_FRUITS; j++) begin
      if (idx_q == IDX_W'(NUM_GHOSTS + j)) begin
        ent_x  = fruit_x[j*COORD_W +: COORD_W];
        ent_y  = fruit_y[j*COORD_W +: COORD_W];
        ent_on = fon_q[j];
      end
    end
  end

  point_dist_sq #(.COORD_W(COORD_W)) u_dist (
    .ax(pac_x_q), .ay(pac_y_q), .bx(ent_x), .by(ent_y), .dist_sq(dist_sq)
  );

  assign hit = ent_on && (dist_sq < DIST_W'(HIT_RADIUS_SQ));

  always_comb begin
    scan_d = scan_q;
    unique case (scan_q)
      IDLE:    if (frame_tick) scan_d = SCAN;
      SCAN:    if (idx_q == IDX_W'(NUM_ENT - 1)) scan_d = COMMIT;
      COMMIT:  scan_d = IDLE;
      default: scan_d = IDLE;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      scan_q      <= IDLE;
      idx_q       <= '0;
      pac_x_q     <= '0;
      pac_y_q     <= '0;
      ghost_hit_q <= '0;
      fruit_hit_q <= '0;
      overrun_q   <= 1'b0;
    end else begin
      scan_q <= scan_d;
      if (scan_q == IDLE && frame_tick) begin
        pac_x_q     <= pacman_x;
        pac_y_q     <= pacman_y;
        idx_q       <= '0;
        ghost_hit_q <= '0;
        fruit_hit_q <= '0;
      end
      if (scan_q == SCAN) begin
        idx_q <= idx_q + IDX_W'(1);
        for (int i = 0; i < NUM_GHOSTS; i++)
          if (hit && idx_q == IDX_W'(i)) ghost_hit_q[i] <= 1'b1;
        for (int j = 0; j < NUM_FRUITS; j++)
          if (hit && idx_q == IDX_W'(NUM_GHOSTS + j)) fruit_hit_q[j] <= 1'b1;
      end
      if (scan_q != IDLE && frame_tick) overrun_q <= 1'b1;
    end
  end

  assign fruit_add = 32'(FRUIT_PTS) * 32'(popcount8(8'(fruit_hit_q)));
  assign ghost_add = 32'(GHOST_PTS) * 32'(popcount8(8'(ghost_hit_q)));

  // Game rules fire only in the single COMMIT cycle of each scan.
  always_comb begin
    game_d     = game_q;
    lives_d    = lives_q;
    power_d    = power_q;
    death_d    = death_q;
    score_d    = score_q;
    gen_d      = gen_q;
    fon_d      = fon_q;
    defeated_d = 1'b0;
    respawn_d  = 1'b0;
    if (scan_q == COMMIT) begin
      unique case (game_q)
        PLAY:
          if (|ghost_hit_q) begin
            defeated_d = 1'b1;
            if (lives_q == '0) begin
              game_d = OVER;
            end else begin
              lives_d = lives_q - LIVES_W'(1);
              death_d = DTH_W'(DEATH_FRAMES);
              game_d  = DYING;
            end
          end else if (|fruit_hit_q) begin
            fon_d   = fon_q & ~fruit_hit_q;
            score_d = sat_add(score_q, fruit_add);
            power_d = PWR_W'(POWER_FRAMES);
            game_d  = POWER;
          end
        POWER: begin
          gen_d   = gen_q & ~ghost_hit_q;
          fon_d   = fon_q & ~fruit_hit_q;
          score_d = sat_add(score_q, fruit_add + ghost_add);
          if (|fruit_hit_q) begin
            power_d = PWR_W'(POWER_FRAMES);
          end else begin
            power_d = (power_q == '0) ? '0 : power_q - PWR_W'(1);
            if (power_q <= PWR_W'(1)) game_d = PLAY;
          end
        end
        DYING: begin
          death_d = (death_q == '0) ? '0 : death_q - DTH_W'(1);
          if (death_q <= DTH_W'(1)) begin
            respawn_d = 1'b1;
            game_d    = PLAY;
          end
        end
        OVER:    game_d = OVER;
        default: game_d = PLAY;
      endcase
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      game_q     <= PLAY;
      lives_q    <= LIVES_W'(LIVES_INIT);
      power_q    <= '0;
      death_q    <= '0;
      score_q    <= '0;
      gen_q      <= '1;
      fon_q      <= '1;
      defeated_q <= 1'b0;
      respawn_q  <= 1'b0;
    end else begin
      game_q     <= game_d;
      lives_q    <= lives_d;
      power_q    <= power_d;
      death_q    <= death_d;
      score_q    <= score_d;
      gen_q      <= gen_d;
      fon_q      <= fon_d;
      defeated_q <= defeated_d;
      respawn_q  <= respawn_d;
    end
  end

  always_comb begin
    reversal     = (game_q == POWER);
    death        = (game_q == OVER);
    isDefeated   = defeated_q;
    respawn      = respawn_q;
    lives        = lives_q;
    score        = score_q;
    ghost_enable = gen_q;
    fruit_on     = fon_q;
    scan_overrun = overrun_q;
  end

endmodule

// File: tb/tb_game_state_ctrl.sv
// Bench for game_state_ctrl: constant vector table, hand-written corner sequences,
// and randomized frames compared against a rule-level model.
module tb_game_state_ctrl;
  import game_pkg::*;

  localparam int NG = 3;
  localparam int NF = 3;
  localparam int CW = 10;

  logic              Clk = 1'b0;
  logic              Reset = 1'b1;
  logic              frame_tick = 1'b0;
  logic [CW-1:0]     pacman_x = '0, pacman_y = '0;
  logic [NG*CW-1:0]  ghost_x = '0, ghost_y = '0;
  logic [NF*CW-1:0]  fruit_x = '0, fruit_y = '0;
  logic [NG-1:0]     ghost_enable;
  logic [NF-1:0]     fruit_on;
  logic              reversal, isDefeated, respawn, death, scan_overrun;
  logic [1:0]        lives;
  logic [15:0]       score;

  always #10 Clk = ~Clk;

  game_state_ctrl #(
    .NUM_GHOSTS(NG), .NUM_FRUITS(NF), .COORD_W(CW), .LIVES_INIT(2), .LIVES_W(2),
    .POWER_FRAMES(600), .DEATH_FRAMES(120), .HIT_RADIUS_SQ(64), .SCORE_W(16),
    .FRUIT_PTS(50), .GHOST_PTS(200)
  ) dut (
    .Clk(Clk), .Reset(Reset), .frame_tick(frame_tick),
    .pacman_x(pacman_x), .pacman_y(pacman_y),
    .ghost_x(ghost_x), .ghost_y(ghost_y), .fruit_x(fruit_x), .fruit_y(fruit_y),
    .ghost_enable(ghost_enable), .fruit_on(fruit_on), .reversal(reversal),
    .isDefeated(isDefeated), .respawn(respawn), .death(death), .lives(lives),
    .score(score), .scan_overrun(scan_overrun)
  );

  int checks = 0;
  int errors = 0;

  int gx[NG], gy[NG], fx[NF], fy[NF];

  // Rule-level reference model.
  localparam int M_PLAY = 0, M_POWER = 1, M_DYING = 2, M_OVER = 3;
  int m_mode, m_lives, m_score, m_power, m_death;
  bit m_gen[NG], m_fon[NF];
  bit m_overrun, m_def, m_resp;

  function automatic int dsq(input int ax, input int ay, input int bx, input int by);
    return (ax - bx) * (ax - bx) + (ay - by) * (ay - by);
  endfunction

  task automatic model_reset();
    m_mode = M_PLAY; m_lives = 2; m_score = 0; m_power = 0; m_death = 0;
    m_overrun = 0; m_def = 0; m_resp = 0;
    for (int i = 0; i < NG; i++) m_gen[i] = 1;
    for (int i = 0; i < NF; i++) m_fon[i] = 1;
  endtask

  task automatic model_add(input int pts);
    m_score = (m_score + pts > 65535) ? 65535 : m_score + pts;
  endtask

  task automatic model_frame(input int px, input int py);
    int ng, nf;
    bit gh[NG];
    bit fh[NF];
    ng = 0; nf = 0; m_def = 0; m_resp = 0;
    for (int i = 0; i < NG; i++) begin
      gh[i] = m_gen[i] && (dsq(px, py, gx[i], gy[i]) < 64);
      ng += int'(gh[i]);
    end
    for (int i = 0; i < NF; i++) begin
      fh[i] = m_fon[i] && (dsq(px, py, fx[i], fy[i]) < 64);
      nf += int'(fh[i]);
    end
    case (m_mode)
      M_PLAY: begin
        if (ng > 0) begin
          m_def = 1;
          if (m_lives == 0) m_mode = M_OVER;
          else begin m_lives--; m_death = 120; m_mode = M_DYING; end
        end else if (nf > 0) begin
          for (int i = 0; i < NF; i++) if (fh[i]) m_fon[i] = 0;
          model_add(50 * nf);
          m_power = 600; m_mode = M_POWER;
        end
      end
      M_POWER: begin
        for (int i = 0; i < NG; i++) if (gh[i]) m_gen[i] = 0;
        for (int i = 0; i < NF; i++) if (fh[i]) m_fon[i] = 0;
        model_add(200 * ng + 50 * nf);
        if (nf > 0) m_power = 600;
        else begin m_power--; if (m_power == 0) m_mode = M_PLAY; end
      end
      M_DYING: begin
        m_death--;
        if (m_death == 0) begin m_resp = 1; m_mode = M_PLAY; end
      end
      default: ;
    endcase
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d", nm, act, exp);
    end
  endtask

  task automatic check_outputs(input string tag);
    logic [NG-1:0] eg;
    logic [NF-1:0] ef;
    for (int i = 0; i < NG; i++) eg[i] = m_gen[i];
    for (int i = 0; i < NF; i++) ef[i] = m_fon[i];
    chk({tag, "/lives"}, 32'(lives), 32'(m_lives));
    chk({tag, "/score"}, 32'(score), 32'(m_score));
    chk({tag, "/ghost_enable"}, 32'(ghost_enable), 32'(eg));
    chk({tag, "/fruit_on"}, 32'(fruit_on), 32'(ef));
    chk({tag, "/reversal"}, 32'(reversal), 32'(m_mode == M_POWER));
    chk({tag, "/death"}, 32'(death), 32'(m_mode == M_OVER));
    chk({tag, "/scan_overrun"}, 32'(scan_overrun), 32'(m_overrun));
  endtask

  task automatic place_ghost(input int i, input int x, input int y);
    gx[i] = x; gy[i] = y;
    ghost_x[i*CW +: CW] = CW'(x);
    ghost_y[i*CW +: CW] = CW'(y);
  endtask

  task automatic park_ghosts();
    for (int i = 0; i < NG; i++) place_ghost(i, 20 + 40 * i, 460);
  endtask

  // One frame: tick, wait for commit (tick+7 Clks), sample on the falling edge.
  task automatic frame(input int px, input int py, input bit full);
    @(negedge Clk);
    pacman_x = CW'(px); pacman_y = CW'(py); frame_tick = 1'b1;
    @(negedge Clk);
    frame_tick = 1'b0;
    repeat (7) @(negedge Clk);
    model_frame(px, py);
    chk("isDefeated", 32'(isDefeated), 32'(m_def));
    chk("respawn", 32'(respawn), 32'(m_resp));
    if (full) check_outputs("frame");
  endtask

  task automatic do_reset();
    @(negedge Clk);
    Reset = 1'b1; frame_tick = 1'b0;
    repeat (2) @(negedge Clk);
    Reset = 1'b0;
    model_reset();
  endtask

  typedef struct {
    int         px, py;
    int         score;
    logic [2:0] fon;
    logic       rev;
  } vec_t;

  vec_t tbl[6];

  initial begin
    tbl[0] = '{300, 300,   0, 3'b111, 1'b0};
    tbl[1] = '{184,  80,  50, 3'b110, 1'b1};
    tbl[2] = '{188,  80,  50, 3'b110, 1'b1};
    tbl[3] = '{400,  87, 100, 3'b100, 1'b1};
    tbl[4] = '{600, 408, 100, 3'b100, 1'b1};
    tbl[5] = '{600, 407, 150, 3'b000, 1'b1};

    fx[0] = 184; fy[0] = 80; fx[1] = 400; fy[1] = 80; fx[2] = 600; fy[2] = 400;
    for (int i = 0; i < NF; i++) begin
      fruit_x[i*CW +: CW] = CW'(fx[i]);
      fruit_y[i*CW +: CW] = CW'(fy[i]);
    end
    park_ghosts();

    // Reset state and fruit table.
    do_reset();
    check_outputs("reset");
    chk("reset/lives_const", 32'(lives), 2);
    for (int i = 0; i < 6; i++) begin
      frame(tbl[i].px, tbl[i].py, 1'b1);
      chk("tbl/score", 32'(score), 32'(tbl[i].score));
      chk("tbl/fruit_on", 32'(fruit_on), 32'(tbl[i].fon));
      chk("tbl/reversal", 32'(reversal), 32'(tbl[i].rev));
      chk("tbl/lives", 32'(lives), 2);
    end

    // Ghost radius boundary in POWER, then the power timer running out.
    place_ghost(1, 303, 304);
    place_ghost(2, 308, 300);
    frame(300, 300, 1'b1);
    chk("pwr/ghost_enable", 32'(ghost_enable), 32'b101);
    chk("pwr/score", 32'(score), 350);
    park_ghosts();
    for (int i = 0; i < 598; i++) frame(300, 300, 1'b0);
    chk("pwr/rev_before_expiry", 32'(reversal), 1);
    frame(300, 300, 1'b1);
    chk("pwr/rev_after_expiry", 32'(reversal), 0);

    // Ghost and fruit in one PLAY frame, then the full death timer.
    do_reset();
    place_ghost(0, 400, 80);
    frame(400, 80, 1'b1);
    chk("die/pulse_hi", 32'(isDefeated), 1);
    chk("die/lives", 32'(lives), 1);
    chk("die/fruit_on", 32'(fruit_on), 32'b111);
    @(negedge Clk);
    chk("die/pulse_lo", 32'(isDefeated), 0);
    for (int i = 0; i < 119; i++) frame(400, 80, 1'b1);
    chk("die/no_early_respawn", 32'(lives), 1);
    frame(400, 80, 1'b1);
    chk("die/respawn_hi", 32'(respawn), 1);
    @(negedge Clk);
    chk("die/respawn_lo", 32'(respawn), 0);
    park_ghosts();
    frame(400, 80, 1'b1);
    chk("die/back_in_play", 32'(reversal), 1);

    // Three deaths lead to OVER, which then ignores everything.
    do_reset();
    for (int k = 0; k < 3; k++) begin
      place_ghost(0, 300, 300);
      frame(300, 300, 1'b1);
      chk("over/lives", 32'(lives), (k == 0) ? 1 : 0);
      chk("over/death", 32'(death), (k == 2) ? 1 : 0);
      park_ghosts();
      if (k < 2) for (int i = 0; i < 120; i++) frame(300, 300, 1'b0);
    end
    place_ghost(0, 184, 80);
    frame(184, 80, 1'b1);
    chk("over/score_frozen", 32'(score), 0);
    chk("over/lives_frozen", 32'(lives), 0);
    chk("over/death_held", 32'(death), 1);

    // Second tick three Clks into a scan; the re-aimed pacman must not commit.
    do_reset();
    park_ghosts();
    @(negedge Clk);
    pacman_x = CW'(184); pacman_y = CW'(80); frame_tick = 1'b1;
    @(negedge Clk);
    frame_tick = 1'b0;
    repeat (2) @(negedge Clk);
    pacman_x = CW'(400); pacman_y = CW'(80); frame_tick = 1'b1;
    @(negedge Clk);
    frame_tick = 1'b0;
    repeat (10) @(negedge Clk);
    model_frame(184, 80);
    m_overrun = 1;
    check_outputs("overrun");
    chk("overrun/one_commit", 32'(score), 50);
    frame(300, 300, 1'b1);

    // Reset in the middle of a scan discards it.
    @(negedge Clk);
    pacman_x = CW'(400); pacman_y = CW'(80); frame_tick = 1'b1;
    @(negedge Clk);
    frame_tick = 1'b0;
    @(negedge Clk);
    Reset = 1'b1;
    @(negedge Clk);
    Reset = 1'b0;
    model_reset();
    check_outputs("midreset");
    chk("midreset/pulse", 32'(isDefeated | respawn), 0);
    repeat (10) @(negedge Clk);
    check_outputs("midreset_settled");

    // Randomized frames against the model.
    for (int round = 0; round < 2; round++) begin
      do_reset();
      for (int n = 0; n < 150; n++) begin
        int r, tx, ty;
        for (int i = 0; i < NG; i++)
          place_ghost(i, int'($urandom_range(20, 620)), int'($urandom_range(20, 460)));
        r = int'($urandom_range(0, 7));
        if (r < 3)      begin tx = gx[r];     ty = gy[r]; end
        else if (r < 6) begin tx = fx[r - 3]; ty = fy[r - 3]; end
        else            begin tx = int'($urandom_range(20, 620)); ty = int'($urandom_range(20, 460)); end
        frame(tx + int'($urandom_range(0, 18)) - 9, ty + int'($urandom_range(0, 18)) - 9, 1'b1);
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
